// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle control unit and its condition checker.
package mcu_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH
   } state_t;

   // ALU operation codes (ALU_EOR only reachable with a control width of 3 or more)
   localparam int unsigned ALU_ADD = 0;
   localparam int unsigned ALU_SUB = 1;
   localparam int unsigned ALU_AND = 2;
   localparam int unsigned ALU_ORR = 3;
   localparam int unsigned ALU_EOR = 4;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_EOR = 4'b0001;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] IMM_DP  = 2'b00;
   localparam logic [1:0] IMM_MEM = 2'b01;
   localparam logic [1:0] IMM_BR  = 2'b10;

endpackage

// File: rtl/mcu_cond_check.sv
// Combinational ARM condition-code evaluation against the stored NZCV flags.
module mcu_cond_check
   import mcu_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] flags,
   output logic       cond_ex_c
);

   logic n, z, c, v;
   assign {n, z, c, v} = flags;

   always_comb begin
      cond_ex_c = 1'b0;
      case (cond)
         COND_EQ: cond_ex_c = z;
         COND_NE: cond_ex_c = ~z;
         COND_CS: cond_ex_c = c;
         COND_CC: cond_ex_c = ~c;
         COND_MI: cond_ex_c = n;
         COND_PL: cond_ex_c = ~n;
         COND_VS: cond_ex_c = v;
         COND_VC: cond_ex_c = ~v;
         COND_HI: cond_ex_c = c & ~z;
         COND_LS: cond_ex_c = ~c | z;
         COND_GE: cond_ex_c = (n == v);
         COND_LT: cond_ex_c = (n != v);
         COND_GT: cond_ex_c = ~z & (n == v);
         COND_LE: cond_ex_c = z | (n != v);
         COND_AL: cond_ex_c = 1'b1;
         default: cond_ex_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-subset controller: FSM sequencing, NZCV flag register, condition check.
// Define CU_BL_EN to support BL (link write of PC+4 to R14 in the BRANCH cycle).
module multicycle_control_unit
   import mcu_pkg::*;
#(
   parameter int unsigned ALU_CTRL_W = 2
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [19:0]           instruction,
   input  logic [3:0]            ALUFlags,
   input  logic                  mem_ready,
   output logic                  PCWrite,
   output logic                  IRWrite,
   output logic                  MemWrite,
   output logic                  RegWrite,
   output logic                  AdrSrc,
   output logic                  ALUSrcA,
   output logic [1:0]            ALUSrcB,
   output logic [1:0]            ResultSrc,
   output logic [1:0]            ImmSrc,
   output logic [1:0]            RegSrc,
   output logic [ALU_CTRL_W-1:0] ALUControl,
   output logic                  link
);

   localparam int unsigned AW = ALU_CTRL_W;

   state_t          state, state_nxt;
   logic [3:0]      flags, flags_nxt;
   logic            cond_ex;
   logic [3:0]      cond, cmd, rd;
   logic [1:0]      op;
   logic            i_bit, s_bit, u_bit, l_bit;
   logic [AW-1:0]   dp_alu;
   logic            dp_logic;
   logic            unused_rn;

   // instruction holds IR[31:12]; field positions are offset by 12
   assign cond      = instruction[19:16];
   assign op        = instruction[15:14];
   assign i_bit     = instruction[13];
   assign cmd       = instruction[12:9];
   assign u_bit     = instruction[11];
   assign s_bit     = instruction[8];
   assign l_bit     = instruction[8];
   assign rd        = instruction[3:0];
   assign unused_rn = ^instruction[7:4];

   mcu_cond_check u_cond (
      .cond      (cond),
      .flags     (flags),
      .cond_ex_c (cond_ex)
   );

   // data-processing ALU op and whether it is a logic op (NZ-only flag update)
   always_comb begin
      dp_alu   = AW'(ALU_ADD);
      dp_logic = 1'b0;
      case (cmd)
         CMD_SUB, CMD_CMP: dp_alu = AW'(ALU_SUB);
         CMD_AND: begin
            dp_alu   = AW'(ALU_AND);
            dp_logic = 1'b1;
         end
         CMD_ORR: begin
            dp_alu   = AW'(ALU_ORR);
            dp_logic = 1'b1;
         end
         CMD_EOR: begin
            if (AW >= 3) begin
               dp_alu   = AW'(ALU_EOR);
               dp_logic = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      flags_nxt = flags;
      if ((state == EXECR || state == EXECI) && s_bit) begin
         if (dp_logic) flags_nxt[3:2] = ALUFlags[3:2];
         else          flags_nxt      = ALUFlags;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         flags <= 4'b0000;
      end else begin
         state <= state_nxt;
         flags <= flags_nxt;
      end
   end

   // next state and decoded outputs; everything held low during reset
   always_comb begin
      state_nxt  = state;
      PCWrite    = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_REG;
      ResultSrc  = RES_ALUOUT;
      ImmSrc     = IMM_DP;
      RegSrc     = 2'b00;
      ALUControl = AW'(ALU_ADD);
      link       = 1'b0;
      if (!reset) begin
         case (state)
            FETCH: begin
               ALUSrcA   = 1'b1;
               ALUSrcB   = SRCB_FOUR;
               ResultSrc = RES_ALU;
               IRWrite   = mem_ready;
               PCWrite   = mem_ready;
               if (mem_ready) state_nxt = DECODE;
            end
            DECODE: begin
               ALUSrcA   = 1'b1;
               ALUSrcB   = SRCB_FOUR;
               ResultSrc = RES_ALU;
               state_nxt = FETCH;
               if (cond_ex) begin
                  case (op)
                     2'b00:   state_nxt = i_bit ? EXECI : EXECR;
                     2'b01:   state_nxt = MEMADR;
                     2'b10:   state_nxt = BRANCH;
                     default: state_nxt = FETCH;
                  endcase
               end
            end
            EXECR, EXECI: begin
               ALUSrcB    = (state == EXECI) ? SRCB_IMM : SRCB_REG;
               ALUControl = dp_alu;
               state_nxt  = ALUWB;
            end
            ALUWB: begin
               RegWrite  = (cmd != CMD_CMP) && (rd != 4'd15);
               state_nxt = FETCH;
            end
            MEMADR: begin
               ALUSrcB    = SRCB_IMM;
               ImmSrc     = IMM_MEM;
               ALUControl = u_bit ? AW'(ALU_ADD) : AW'(ALU_SUB);
               state_nxt  = l_bit ? MEMRD : MEMWR;
            end
            MEMRD: begin
               AdrSrc = 1'b1;
               if (mem_ready) state_nxt = MEMWB;
            end
            MEMWB: begin
               ResultSrc = RES_DATA;
               RegWrite  = 1'b1;
               state_nxt = FETCH;
            end
            MEMWR: begin
               AdrSrc   = 1'b1;
               MemWrite = 1'b1;
               RegSrc   = 2'b10;
               if (mem_ready) state_nxt = FETCH;
            end
            BRANCH: begin
               ALUSrcB   = SRCB_IMM;
               ImmSrc    = IMM_BR;
               ResultSrc = RES_ALU;
               PCWrite   = 1'b1;
               RegSrc    = 2'b01;
`ifdef CU_BL_EN
               if (instruction[12]) begin
                  link     = 1'b1;
                  RegWrite = 1'b1;
               end
`endif
               state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
         endcase
      end
   end

endmodule
